// File: rtl/rtc_access_sched.sv
// Round-robin arbiter and burst sequencer that drives the multiplexed RTC chip bus for the time/date/timer clients.
// Busy for 1+NBYTES*(2*T_STB+2*T_GAP)+1 cycles; no backpressure: requests wait in IDLE, wdata must be valid throughout D_STB.
module rtc_access_sched #(
    parameter int          NBYTES     = 3,
    parameter int          T_STB      = 4,
    parameter int          T_GAP      = 2,
    parameter logic [7:0]  BASE_TIME  = 8'h21,
    parameter logic [7:0]  BASE_DATE  = 8'h24,
    parameter logic [7:0]  BASE_TIMER = 8'h41
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_req_time,
    input  logic       i_req_date,
    input  logic       i_req_timer,
    input  logic       i_wr,
    input  logic [7:0] i_wdata,
    output logic [1:0] o_grant,
    output logic       o_busy,
    output logic [1:0] o_byte_idx,
    output logic       o_wdata_ack,
    output logic [7:0] o_rdata,
    output logic       o_rdata_vld,
    output logic       o_done,
    output logic       o_cs_n,
    output logic       o_rd_n,
    output logic       o_wr_n,
    output logic       o_a_d,
    output logic [7:0] o_ad_out,
    output logic       o_ad_oe,
    input  logic [7:0] i_ad_in
);

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_A_STB, S_A_HOLD, S_D_STB, S_D_HOLD, S_DONE
    } state_t;

    state_t     r_state, w_next;
    logic [7:0] r_cnt;
    logic [1:0] r_grant, r_rr, r_idx, w_win;
    logic       r_wr, r_rdata_vld;
    logic [7:0] r_wdat, r_rdata, w_base, w_addr;
    logic       w_stb_end, w_gap_end, w_last;

    assign w_stb_end = (r_cnt == 8'(T_STB - 1));
    assign w_gap_end = (r_cnt == 8'(T_GAP - 1));
    assign w_last    = (r_idx == 2'(NBYTES - 1));

    // First requester after the last-granted client, order time -> date -> timer -> time.
    always_comb begin
        w_win = 2'd0;
        case (r_rr)
            2'd1:    w_win = i_req_date  ? 2'd2 : i_req_timer ? 2'd3 : i_req_time  ? 2'd1 : 2'd0;
            2'd2:    w_win = i_req_timer ? 2'd3 : i_req_time  ? 2'd1 : i_req_date  ? 2'd2 : 2'd0;
            default: w_win = i_req_time  ? 2'd1 : i_req_date  ? 2'd2 : i_req_timer ? 2'd3 : 2'd0;
        endcase
    end

    always_comb begin
        w_base = 8'h00;
        case (r_grant)
            2'd1:    w_base = BASE_TIME;
            2'd2:    w_base = BASE_DATE;
            2'd3:    w_base = BASE_TIMER;
            default: w_base = 8'h00;
        endcase
    end

    assign w_addr = w_base + {6'b0, r_idx};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_win != 2'd0) w_next = S_GRANT;
            S_GRANT:  w_next = S_A_STB;
            S_A_STB:  if (w_stb_end) w_next = S_A_HOLD;
            S_A_HOLD: if (w_gap_end) w_next = S_D_STB;
            S_D_STB:  if (w_stb_end) w_next = S_D_HOLD;
            S_D_HOLD: if (w_gap_end) w_next = w_last ? S_DONE : S_A_STB;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt       <= 8'd0;
            r_grant     <= 2'd0;
            r_rr        <= 2'd3;
            r_idx       <= 2'd0;
            r_wr        <= 1'b0;
            r_wdat      <= 8'h00;
            r_rdata     <= 8'h00;
            r_rdata_vld <= 1'b0;
        end else begin
            r_cnt       <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
            r_rdata_vld <= 1'b0;
            case (r_state)
                S_IDLE: if (w_next == S_GRANT) begin
                    r_grant <= w_win;
                    r_wr    <= i_wr;
                    r_idx   <= 2'd0;
                end
                S_D_STB: if (w_stb_end) begin
                    if (r_wr) begin
                        r_wdat <= i_wdata;
                    end else begin
                        r_rdata     <= i_ad_in;
                        r_rdata_vld <= 1'b1;
                    end
                end
                S_D_HOLD: if (w_gap_end && !w_last) r_idx <= r_idx + 2'd1;
                S_DONE: begin
                    r_rr    <= r_grant;
                    r_grant <= 2'd0;
                    r_idx   <= 2'd0;
                end
                default: ;
            endcase
        end
    end

    // Bus pins decode straight from state so an async reset releases them immediately.
    always_comb begin
        o_cs_n      = 1'b1;
        o_rd_n      = 1'b1;
        o_wr_n      = 1'b1;
        o_a_d       = 1'b0;
        o_ad_oe     = 1'b0;
        o_ad_out    = 8'h00;
        o_wdata_ack = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            S_GRANT, S_A_HOLD: begin
                o_cs_n   = 1'b0;
                o_ad_oe  = 1'b1;
                o_ad_out = w_addr;
            end
            S_A_STB: begin
                o_cs_n   = 1'b0;
                o_ad_oe  = 1'b1;
                o_ad_out = w_addr;
                o_wr_n   = 1'b0;
            end
            S_D_STB: begin
                o_cs_n = 1'b0;
                o_a_d  = 1'b1;
                if (r_wr) begin
                    o_ad_oe     = 1'b1;
                    o_ad_out    = i_wdata;
                    o_wr_n      = 1'b0;
                    o_wdata_ack = w_stb_end;
                end else begin
                    o_rd_n = 1'b0;
                end
            end
            S_D_HOLD: begin
                o_cs_n   = 1'b0;
                o_a_d    = 1'b1;
                o_ad_oe  = r_wr;
                o_ad_out = r_wr ? r_wdat : 8'h00;
            end
            S_DONE:  o_done = 1'b1;
            default: ;
        endcase
    end

    assign o_grant     = r_grant;
    assign o_busy      = (r_state != S_IDLE);
    assign o_byte_idx  = r_idx;
    assign o_rdata     = r_rdata;
    assign o_rdata_vld = r_rdata_vld;

endmodule

// File: tb/tb_rtc_access_sched.sv
// Scoreboard bench for rtc_access_sched: default instance plus a T_STB=T_GAP=1 instance.
module tb_rtc_access_sched;

    localparam int T_STB_A = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_time, req_date, req_timer, wr;
    logic [7:0] wdata, ad_in;
    logic [1:0] grant, byte_idx;
    logic       busy, wdata_ack, rdata_vld, done, cs_n, rd_n, wr_n, a_d, ad_oe;
    logic [7:0] rdata, ad_out;

    logic       b_req_time, b_req_date, b_req_timer, b_wr;
    logic [7:0] b_wdata, b_ad_in;
    logic [1:0] b_grant, b_byte_idx;
    logic       b_busy, b_wdata_ack, b_rdata_vld, b_done, b_cs_n, b_rd_n, b_wr_n, b_a_d, b_ad_oe;
    logic [7:0] b_rdata, b_ad_out;

    always #5 clk = ~clk;

    rtc_access_sched dut (
        .i_clk(clk), .i_reset(reset), .i_req_time(req_time), .i_req_date(req_date),
        .i_req_timer(req_timer), .i_wr(wr), .i_wdata(wdata), .o_grant(grant), .o_busy(busy),
        .o_byte_idx(byte_idx), .o_wdata_ack(wdata_ack), .o_rdata(rdata), .o_rdata_vld(rdata_vld),
        .o_done(done), .o_cs_n(cs_n), .o_rd_n(rd_n), .o_wr_n(wr_n), .o_a_d(a_d),
        .o_ad_out(ad_out), .o_ad_oe(ad_oe), .i_ad_in(ad_in)
    );

    rtc_access_sched #(.T_STB(1), .T_GAP(1)) dut_fast (
        .i_clk(clk), .i_reset(reset), .i_req_time(b_req_time), .i_req_date(b_req_date),
        .i_req_timer(b_req_timer), .i_wr(b_wr), .i_wdata(b_wdata), .o_grant(b_grant), .o_busy(b_busy),
        .o_byte_idx(b_byte_idx), .o_wdata_ack(b_wdata_ack), .o_rdata(b_rdata), .o_rdata_vld(b_rdata_vld),
        .o_done(b_done), .o_cs_n(b_cs_n), .o_rd_n(b_rd_n), .o_wr_n(b_wr_n), .o_a_d(b_a_d),
        .o_ad_out(b_ad_out), .o_ad_oe(b_ad_oe), .i_ad_in(b_ad_in)
    );

    typedef struct {
        logic [1:0] grant;
        int         len;
        int         nwr;
        int         nrd;
    } burst_t;

    burst_t     q_burst[$];
    logic [7:0] q_addr[$], q_wdat[$], q_rd[$];
    burst_t     mb;
    int         n_chk = 0, n_fail = 0;
    int         busy_cnt, wr_falls, rd_falls, wr_run, rd_run;
    int         done_cnt = 0;
    logic       pw, pr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_burst(input logic [1:0] g, input bit w, input logic [7:0] rd,
                              input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                              input int len);
        logic [7:0] base;
        logic [7:0] wv[3];
        wv = '{w0, w1, w2};
        base = (g == 2'd1) ? 8'h21 : (g == 2'd2) ? 8'h24 : 8'h41;
        for (int i = 0; i < 3; i++) begin
            q_addr.push_back(base + 8'(i));
            if (w) q_wdat.push_back(wv[i]);
            else   q_rd.push_back(rd);
        end
        q_burst.push_back('{grant: g, len: len, nwr: (w ? 6 : 3), nrd: (w ? 0 : 3)});
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(done), 1);
    endtask

    // Monitor for the default instance: pops expectations as bus events appear.
    always @(negedge clk) begin
        if (!reset) begin
            busy_cnt = 0; wr_falls = 0; rd_falls = 0; wr_run = 0; rd_run = 0;
            pw = 1'b1; pr = 1'b1;
        end else begin
            if (busy) busy_cnt++;
            if (!rd_n || !wr_n) begin
                chk("strobe_excl", 32'(rd_n ^ wr_n), 1);
                chk("strobe_cs", 32'(cs_n), 0);
            end
            if (!wr_n) wr_run++;
            if (!rd_n) rd_run++;
            if (pw && !wr_n) begin
                wr_falls++;
                chk("wr_oe", 32'(ad_oe), 1);
                if (!a_d) begin
                    chk("addr_q_avail", 32'(q_addr.size() != 0), 1);
                    if (q_addr.size() != 0) chk("addr", 32'(ad_out), 32'(q_addr.pop_front()));
                end else begin
                    chk("wdat_q_avail", 32'(q_wdat.size() != 0), 1);
                    if (q_wdat.size() != 0) chk("wdata_bus", 32'(ad_out), 32'(q_wdat.pop_front()));
                end
            end
            if (!pw && wr_n) begin
                chk("wr_width", wr_run, T_STB_A);
                wr_run = 0;
            end
            if (pr && !rd_n) begin
                rd_falls++;
                chk("rd_phase", 32'({a_d, ad_oe}), 32'h2);
            end
            if (!pr && rd_n) begin
                chk("rd_width", rd_run, T_STB_A);
                rd_run = 0;
            end
            if (rdata_vld) begin
                chk("rd_q_avail", 32'(q_rd.size() != 0), 1);
                if (q_rd.size() != 0) chk("rdata", 32'(rdata), 32'(q_rd.pop_front()));
            end
            if (done) begin
                done_cnt++;
                chk("burst_q_avail", 32'(q_burst.size() != 0), 1);
                if (q_burst.size() != 0) begin
                    mb = q_burst.pop_front();
                    chk("grant", 32'(grant), 32'(mb.grant));
                    chk("busy_len", busy_cnt, mb.len);
                    chk("wr_strobes", wr_falls, mb.nwr);
                    chk("rd_strobes", rd_falls, mb.nrd);
                end
                busy_cnt = 0; wr_falls = 0; rd_falls = 0;
            end
            pw = wr_n;
            pr = rd_n;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] wv[3];
        logic [1:0] rr_exp[4];
        int         k, wi, d0;
        int         bb, bwl, brl, bwf, bvld, back;
        logic       bpw;

        wv     = '{8'h30, 8'h45, 8'h12};
        rr_exp = '{2'd1, 2'd2, 2'd3, 2'd1};
        reset = 1'b0; req_time = 0; req_date = 0; req_timer = 0; wr = 0; wdata = 8'h00; ad_in = 8'h00;
        b_req_time = 0; b_req_date = 0; b_req_timer = 0; b_wr = 0; b_wdata = 8'h00; b_ad_in = 8'h5A;
        repeat (3) @(negedge clk);

        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_idx", 32'(byte_idx), 0);
        chk("rst_pulses", 32'({wdata_ack, rdata_vld, done}), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_strobes", 32'({cs_n, rd_n, wr_n}), 32'h7);
        chk("rst_bus", 32'({a_d, ad_oe, ad_out}), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single read burst on the date registers.
        ad_in = 8'h15; wr = 1'b0;
        push_burst(2'd2, 1'b0, 8'h15, 8'h00, 8'h00, 8'h00, 38);
        req_date = 1'b1;
        wait_done("t1_done", 100);
        req_date = 1'b0;
        repeat (3) @(negedge clk);

        // Write burst on the time registers; wdata advances after each ack.
        wdata = wv[0]; wr = 1'b1;
        push_burst(2'd1, 1'b1, 8'h00, wv[0], wv[1], wv[2], 38);
        req_time = 1'b1;
        k = 0; wi = 0;
        do begin
            @(negedge clk);
            k++;
            if (wdata_ack) begin
                wi++;
                if (wi < 3) begin
                    @(posedge clk);
                    #1 wdata = wv[wi];
                end
            end
        end while (!done && k < 100);
        chk("t2_done", 32'(done), 1);
        chk("t2_acks", wi, 3);
        req_time = 1'b0; wr = 1'b0;
        repeat (3) @(negedge clk);

        // Round robin from a fresh reset with all three clients requesting.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        ad_in = 8'h15;
        for (int i = 0; i < 4; i++) push_burst(rr_exp[i], 1'b0, 8'h15, 8'h00, 8'h00, 8'h00, 38);
        req_time = 1'b1; req_date = 1'b1; req_timer = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_done("t3_done", 100);
            if (i < 3) begin
                @(negedge clk);
                chk("rr_gap_grant", 32'(grant), 0);
                chk("rr_gap_busy", 32'(busy), 0);
                @(negedge clk);
                chk("rr_next_busy", 32'(busy), 1);
                chk("rr_next_grant", 32'(grant), 32'(rr_exp[i+1]));
            end
        end
        req_time = 1'b0; req_date = 1'b0; req_timer = 1'b0;
        repeat (3) @(negedge clk);

        // One-cycle timer request still yields a full burst and a single done.
        d0 = done_cnt;
        push_burst(2'd3, 1'b0, 8'h15, 8'h00, 8'h00, 8'h00, 38);
        @(negedge clk) req_timer = 1'b1;
        @(negedge clk) req_timer = 1'b0;
        wait_done("t4_done", 100);
        repeat (20) @(negedge clk);
        chk("drop_done_once", done_cnt - d0, 1);
        chk("drop_idle", 32'(busy), 0);

        // Asynchronous reset during the data strobe of byte 1.
        ad_in = 8'hA7;
        push_burst(2'd2, 1'b0, 8'hA7, 8'h00, 8'h00, 8'h00, 38);
        req_date = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(byte_idx == 2'd1 && !rd_n) && k < 100);
        chk("t5_reach_dstb1", 32'(byte_idx == 2'd1 && !rd_n), 1);
        #1 reset = 1'b0;
        #1;
        chk("arst_strobes", 32'({cs_n, rd_n, wr_n}), 32'h7);
        chk("arst_oe", 32'(ad_oe), 0);
        chk("arst_grant", 32'(grant), 0);
        chk("arst_busy", 32'(busy), 0);
        q_burst.delete(); q_addr.delete(); q_wdat.delete(); q_rd.delete();
        push_burst(2'd2, 1'b0, 8'hA7, 8'h00, 8'h00, 8'h00, 38);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_restart_idx", 32'(byte_idx), 0);
        wait_done("t5_done", 100);
        req_date = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_drained", q_burst.size() + q_addr.size() + q_rd.size() + q_wdat.size(), 0);

        // Minimum timing instance: single-cycle strobes and gaps.
        bb = 0; bwl = 0; brl = 0; bwf = 0; bvld = 0; back = 0; bpw = 1'b1; k = 0;
        b_req_time = 1'b1;
        do begin
            @(negedge clk);
            k++;
            if (b_busy) bb++;
            if (!b_wr_n) bwl++;
            if (!b_rd_n) brl++;
            if (b_wdata_ack) back++;
            if (!b_rd_n || !b_wr_n) begin
                chk("f_excl", 32'(b_rd_n ^ b_wr_n), 1);
                chk("f_cs", 32'(b_cs_n), 0);
            end
            if (bpw && !b_wr_n) begin
                chk("f_addr", 32'(b_ad_out), 32'(8'h21 + 8'(bwf)));
                bwf++;
            end
            if (b_rdata_vld) begin
                bvld++;
                chk("f_rdata", 32'(b_rdata), 32'h5A);
            end
            bpw = b_wr_n;
        end while (!b_done && k < 60);
        chk("f_done", 32'(b_done), 1);
        chk("f_grant", 32'(b_grant), 1);
        chk("f_last_idx", 32'(b_byte_idx), 2);
        chk("f_done_bus", 32'({b_a_d, b_ad_oe}), 0);
        b_req_time = 1'b0;
        chk("f_busy_len", bb, 14);
        chk("f_wr_low", bwl, 3);
        chk("f_rd_low", brl, 3);
        chk("f_vld", bvld, 3);
        chk("f_no_ack", back, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
